boot_ahb_bridge: RTL

Boot-control bus responder: accepts single 128-bit read/write requests from boot-time controllers (firmware authentication, key loading) over the go/done request interface and executes each as one AHB-Lite INCR4 burst of 32-bit words. Sits between the boot-control request mux and the SoC AHB-Lite fabric as the only AHB master on the boot path.

---
 rtl/boot_ahb_bridge_if.sv | 43 ++++
 rtl/boot_ahb_bridge.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/boot_ahb_bridge_if.sv
// Boot-control bridge bundle: the go/done request port from the boot
// controllers plus the AHB-Lite master port toward the SoC fabric.
// The master modport is the bridge (it masters AHB and serves requests);
// the slave modport is the environment (requester and AHB responder).
interface boot_ahb_bridge_if #(
  parameter int pAHB_ADDR_WIDTH    = 32,
  parameter int pAHB_DATA_WIDTH    = 32,
  parameter int pPAYLOAD_SIZE_BITS = 128
);
  // request side
  logic                          bus_go;
  logic [pAHB_ADDR_WIDTH-1:0]    bus_addr;
  logic                          bus_RW;
  logic [pPAYLOAD_SIZE_BITS-1:0] bus_write;
  logic                          bus_done;
  logic [pPAYLOAD_SIZE_BITS-1:0] bus_rdData;
  logic                          bus_err;
  logic                          bus_busy;
  // AHB-Lite side
  logic [pAHB_ADDR_WIDTH-1:0]    HADDR;
  logic [1:0]                    HTRANS;
  logic                          HWRITE;
  logic [2:0]                    HSIZE;
  logic [2:0]                    HBURST;
  logic [pAHB_DATA_WIDTH-1:0]    HWDATA;
  logic [pAHB_DATA_WIDTH-1:0]    HRDATA;
  logic                          HREADY;
  logic                          HRESP;

  modport master (
    input  bus_go, bus_addr, bus_RW, bus_write,
    output bus_done, bus_rdData, bus_err, bus_busy,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    output bus_go, bus_addr, bus_RW, bus_write,
    input  bus_done, bus_rdData, bus_err, bus_busy,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/boot_ahb_bridge.sv
// Boot-path AHB-Lite master: each 128-bit go/done request becomes one
// INCR4 burst of 32-bit words. Address and data phases are pipelined and
// share HREADY, so the data phase in flight is always the previously
// accepted address beat. An ERROR response cancels the pending address
// phase and completes the request with bus_err set.
module boot_ahb_bridge #(
  parameter int pAHB_ADDR_WIDTH    = 32,
  parameter int pAHB_DATA_WIDTH    = 32,
  parameter int pPAYLOAD_SIZE_BITS = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  boot_ahb_bridge_if.master     bif
);

  localparam int AW = pAHB_ADDR_WIDTH;
  localparam int DW = pAHB_DATA_WIDTH;
  localparam int PW = pPAYLOAD_SIZE_BITS;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [1:0] LAST_BEAT    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BURST = 3'd1,
    ST_DRAIN = 3'd2,
    ST_ERR   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t          state_r;
  logic [1:0]      a_r;         // address-phase beat
  logic [1:0]      d_r;         // data-phase beat
  logic            dp_r;        // a data phase is in flight during BURST
  logic            rw_r;
  logic [PW-1:0]   wr_data_r;
  logic [PW-1:0]   rd_data_r;
  logic [AW-1:0]   haddr_r;
  logic [1:0]      htrans_r;
  logic            hwrite_r;
  logic [DW-1:0]   hwdata_r;
  logic            done_r;
  logic            err_r;
  logic            busy_r;

  // Word k of a payload lives at bits [32k+31:32k].
  function automatic logic [DW-1:0] word_sel(input logic [PW-1:0] p,
                                             input logic [1:0]    k);
    word_sel = p[{k, 5'b00000} +: DW];
  endfunction

  // Request sequencing, AHB phase generation and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      a_r       <= 2'd0;
      d_r       <= 2'd0;
      dp_r      <= 1'b0;
      rw_r      <= 1'b0;
      wr_data_r <= {PW{1'b0}};
      rd_data_r <= {PW{1'b0}};
      haddr_r   <= {AW{1'b0}};
      htrans_r  <= TRANS_IDLE;
      hwrite_r  <= 1'b0;
      hwdata_r  <= {DW{1'b0}};
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bif.bus_go) begin
            haddr_r   <= {bif.bus_addr[AW-1:4], 4'b0000};
            rw_r      <= bif.bus_RW;
            hwrite_r  <= bif.bus_RW;
            wr_data_r <= bif.bus_write;
            rd_data_r <= {PW{1'b0}};
            err_r     <= 1'b0;
            htrans_r  <= TRANS_NONSEQ;
            a_r       <= 2'd0;
            d_r       <= 2'd0;
            dp_r      <= 1'b0;
            busy_r    <= 1'b1;
            state_r   <= ST_BURST;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_BURST: begin
          if (dp_r && bif.HRESP && !bif.HREADY) begin
            // first ERROR cycle: withdraw the pending address phase
            htrans_r <= TRANS_IDLE;
            state_r  <= ST_ERR;
          end else if (bif.HREADY) begin
            if (dp_r && !rw_r) begin
              rd_data_r[{d_r, 5'b00000} +: DW] <= bif.HRDATA;
            end else begin
              rd_data_r <= rd_data_r;
            end
            // the accepted address beat becomes the new data phase
            dp_r     <= 1'b1;
            d_r      <= a_r;
            hwdata_r <= rw_r ? word_sel(wr_data_r, a_r) : {DW{1'b0}};
            if (a_r == LAST_BEAT) begin
              htrans_r <= TRANS_IDLE;
              state_r  <= ST_DRAIN;
            end else begin
              a_r      <= a_r + 2'd1;
              haddr_r  <= haddr_r + AW'(4);
              htrans_r <= TRANS_SEQ;
            end
          end else begin
            state_r <= ST_BURST;    // wait state: everything held
          end
        end

        ST_DRAIN: begin
          if (bif.HRESP && !bif.HREADY) begin
            state_r <= ST_ERR;
          end else if (bif.HREADY) begin
            if (!rw_r) begin
              rd_data_r[{d_r, 5'b00000} +: DW] <= bif.HRDATA;
            end else begin
              rd_data_r <= rd_data_r;
            end
            hwdata_r <= {DW{1'b0}};
            hwrite_r <= 1'b0;
            done_r   <= 1'b1;
            state_r  <= ST_DONE;
          end else begin
            state_r <= ST_DRAIN;
          end
        end

        ST_ERR: begin
          if (bif.HRESP && bif.HREADY) begin
            hwdata_r <= {DW{1'b0}};
            hwrite_r <= 1'b0;
            err_r    <= 1'b1;
            done_r   <= 1'b1;
            state_r  <= ST_DONE;
          end else begin
            state_r <= ST_ERR;
          end
        end

        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          htrans_r <= TRANS_IDLE;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bif.HADDR      = haddr_r;
  assign bif.HTRANS     = htrans_r;
  assign bif.HWRITE     = hwrite_r;
  assign bif.HWDATA     = hwdata_r;
  assign bif.HSIZE      = 3'b010;
  assign bif.HBURST     = 3'b011;
  assign bif.bus_done   = done_r;
  assign bif.bus_err    = err_r;
  assign bif.bus_busy   = busy_r;
  assign bif.bus_rdData = rd_data_r;

endmodule
